// File: rtl/cordic_rotation_seq_if.sv
// Host and engine signal bundle for the CORDIC rotation sequencer.
// slave is the sequencer side; master is the host/engine side.
interface cordic_rotation_seq_if #(
    parameter int WIDTH = 24
);
    localparam int W = WIDTH + 2;

    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_theta;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_cos;
    logic signed [W-1:0] out_sin;
    logic                out_range_err;
    logic [4:0]          eng_i;
    logic signed [W-1:0] eng_a;
    logic signed [W-1:0] eng_x;
    logic signed [W-1:0] eng_y;
    logic signed [W-1:0] eng_w;
    logic signed [W-1:0] eng_x_n;
    logic signed [W-1:0] eng_y_n;
    logic signed [W-1:0] eng_w_n;

    modport slave (
        input  in_valid, in_theta, out_ready, eng_x_n, eng_y_n, eng_w_n,
        output in_ready, out_valid, out_cos, out_sin, out_range_err,
               eng_i, eng_a, eng_x, eng_y, eng_w
    );

    modport master (
        output in_valid, in_theta, out_ready, eng_x_n, eng_y_n, eng_w_n,
        input  in_ready, out_valid, out_cos, out_sin, out_range_err,
               eng_i, eng_a, eng_x, eng_y, eng_w
    );
endinterface

// File: rtl/cordic_rotation_seq.sv
// Iterative CORDIC rotation-mode sequencer: seeds x/y/w, walks the external
// single-stage engine through ITER micro-rotations, then holds cos/sin.
module cordic_rotation_seq #(
    parameter int WIDTH = 24,
    parameter int ITER  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cordic_rotation_seq_if.slave bus
);
    localparam int W  = WIDTH + 2;
    localparam int FB = 64;

    // Truncation reproduces the reference constants exactly at WIDTH=24.
    localparam logic signed [W-1:0] K        = W'($rtoi(0.6072529350 * (2.0 ** WIDTH)));
    localparam logic signed [W-1:0] PI_2     = W'($rtoi(1.5707963268 * (2.0 ** WIDTH)));
    localparam logic signed [W-1:0] NEG_PI_2 = -PI_2;

    // atan(2^-i) via Euler's series; with x=2^-i every term ratio is an
    // integer fraction, so the whole sum stays in exact fixed point.
    function automatic logic [W-1:0] atan_fx(input int i);
        logic [127:0] den, term, sum, nn;
        den  = (128'd1 << (2 * i)) + 128'd1;
        term = (128'd1 << (FB + i)) / den;
        sum  = '0;
        for (int n = 1; n <= 120; n++) begin
            sum  = sum + term;
            nn   = 128'(n);
            term = (term * (nn + nn)) / ((nn + nn + 128'd1) * den);
        end
        sum = (sum + (128'd1 << (FB - WIDTH - 1))) >> (FB - WIDTH);
        return sum[W-1:0];
    endfunction

    logic signed [W-1:0] rom [32];

    for (genvar g = 0; g < 32; g++) begin : g_rom
        localparam logic signed [W-1:0] A = (g < ITER) ? atan_fx(g) : '0;
        assign rom[g] = A;
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_n;
    logic [4:0]          cnt;
    logic signed [W-1:0] x, y, w;
    logic                range_err;
    logic                load, step, last;

    assign last = (cnt == 5'(ITER - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n      = state;
        bus.in_ready = 1'b0;
        bus.out_valid = 1'b0;
        load         = 1'b0;
        step         = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_n = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt       <= '0;
            x         <= '0;
            y         <= '0;
            w         <= '0;
            range_err <= 1'b0;
        end else if (load) begin
            cnt       <= '0;
            x         <= K;
            y         <= '0;
            w         <= bus.in_theta;
            range_err <= (bus.in_theta > PI_2) || (bus.in_theta < NEG_PI_2);
        end else if (step) begin
            x <= bus.eng_x_n;
            y <= bus.eng_y_n;
            w <= bus.eng_w_n;
            if (!last) cnt <= cnt + 5'd1;
        end
    end

    assign bus.out_cos       = x;
    assign bus.out_sin       = y;
    assign bus.out_range_err = range_err;
    assign bus.eng_i         = cnt;
    assign bus.eng_a         = rom[cnt];
    assign bus.eng_x         = x;
    assign bus.eng_y         = y;
    assign bus.eng_w         = w;
endmodule

// File: tb/tb_cordic_rotation_seq.sv
// Bench for cordic_rotation_seq: models the rotation engine, checks every RUN
// cycle against a golden trajectory and every result through a scoreboard.
module tb_cordic_rotation_seq;
    localparam int WIDTH = 24;
    localparam int ITER  = 16;
    localparam int W     = WIDTH + 2;
    localparam int K_TB  = 10188013;
    localparam int PI_2  = 26353589;
    localparam int ONE   = 16777216;
    localparam int TOL   = 1024;

    typedef logic signed [W-1:0] word_t;
    typedef struct packed { word_t x; word_t y; word_t w; } xyw_t;
    typedef struct { int theta; int ec; int es; bit ee; } vec_t;
    typedef struct { int theta; int ec; int es; bit ee; int mc; int ms; } rec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    cordic_rotation_seq_if #(.WIDTH(WIDTH)) bus();
    cordic_rotation_seq #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    rec_t  sbq[$];
    int    rdy_mode = 0;
    bit    rdy_manual = 1'b0;
    word_t tx[ITER+1], ty[ITER+1], tw[ITER+1];
    xyw_t  eng_s;

    function automatic int atan_tb(int k);
        return $rtoi($atan(1.0 / (2.0 ** k)) * 16777216.0 + 0.5);
    endfunction

    function automatic xyw_t rot(xyw_t s, int i, word_t a);
        word_t x, y, w;
        xyw_t  r;
        x = s.x; y = s.y; w = s.w;
        if (w >= 0) begin
            r.x = x - (y >>> i); r.y = y + (x >>> i); r.w = w - a;
        end else begin
            r.x = x + (y >>> i); r.y = y - (x >>> i); r.w = w + a;
        end
        return r;
    endfunction

    // Engine stand-in: one combinational micro-rotation.
    always_comb begin
        eng_s = rot('{bus.eng_x, bus.eng_y, bus.eng_w}, int'(bus.eng_i), bus.eng_a);
        bus.eng_x_n = eng_s.x;
        bus.eng_y_n = eng_s.y;
        bus.eng_w_n = eng_s.w;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_tol(input string nm, input longint act, input longint exp);
        checks++;
        if (act - exp > TOL || exp - act > TOL) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d +/-%0d", nm, act, exp, TOL);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ready_drv();
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(1));
                default: bus.out_ready = rdy_manual;
            endcase
        end
    endtask

    task automatic monitor();
        bit    active = 1'b0, held = 1'b0, post_hs = 1'b0;
        int    k = 0;
        word_t hc = '0, hs = '0;
        rec_t  r;
        xyw_t  s;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                active = 1'b0; held = 1'b0; post_hs = 1'b0;
                sbq.delete();
            end else begin
                if (post_hs) begin
                    chk("in_ready after handshake", bus.in_ready, 1);
                    post_hs = 1'b0;
                end
                if (active) begin
                    if (k < ITER) begin
                        chk("eng_i", bus.eng_i, k);
                        chk("eng_a", bus.eng_a, atan_tb(k));
                        chk("eng_x", bus.eng_x, tx[k]);
                        chk("eng_y", bus.eng_y, ty[k]);
                        chk("eng_w", bus.eng_w, tw[k]);
                        chk("in_ready in RUN", bus.in_ready, 0);
                        chk("out_valid early", bus.out_valid, 0);
                        k++;
                    end else begin
                        chk("out_valid latency", bus.out_valid, 1);
                        active = 1'b0;
                    end
                end
                if (bus.in_valid && bus.in_ready) begin
                    s = '{word_t'(K_TB), word_t'(0), bus.in_theta};
                    tx[0] = s.x; ty[0] = s.y; tw[0] = s.w;
                    for (int j = 0; j < ITER; j++) begin
                        s = rot(s, j, word_t'(atan_tb(j)));
                        tx[j+1] = s.x; ty[j+1] = s.y; tw[j+1] = s.w;
                    end
                    active = 1'b1;
                    k = 0;
                end
                if (bus.out_valid) begin
                    chk("in_ready in DONE", bus.in_ready, 0);
                    if (held) begin
                        chk("out_cos stable", bus.out_cos, hc);
                        chk("out_sin stable", bus.out_sin, hs);
                    end
                    if (bus.out_ready) begin
                        if (sbq.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL spurious result: cos %0d sin %0d with nothing expected",
                                     bus.out_cos, bus.out_sin);
                        end else begin
                            r = sbq.pop_front();
                            chk_tol($sformatf("cos theta=%0d", r.theta), bus.out_cos, r.ec);
                            chk_tol($sformatf("sin theta=%0d", r.theta), bus.out_sin, r.es);
                            chk($sformatf("range_err theta=%0d", r.theta), bus.out_range_err, r.ee);
                            chk($sformatf("cos model theta=%0d", r.theta), bus.out_cos, r.mc);
                            chk($sformatf("sin model theta=%0d", r.theta), bus.out_sin, r.ms);
                        end
                        held = 1'b0;
                        post_hs = 1'b1;
                    end else begin
                        held = 1'b1;
                        hc = bus.out_cos;
                        hs = bus.out_sin;
                    end
                end
            end
        end
    endtask

    task automatic send(input int theta, input int ec, input int es, input bit ee);
        xyw_t  s;
        rec_t  r;
        word_t xx, yy;
        bit    acc = 1'b0;
        s = '{word_t'(K_TB), word_t'(0), word_t'(theta)};
        for (int j = 0; j < ITER; j++) s = rot(s, j, word_t'(atan_tb(j)));
        xx = s.x; yy = s.y;
        r = '{theta, ec, es, ee, int'(xx), int'(yy)};
        sbq.push_back(r);
        bus.in_theta = word_t'(theta);
        bus.in_valid = 1'b1;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept timeout theta=%0d: in_ready never 1 in 200 cycles", theta);
        end
    endtask

    task automatic drain(input int max);
        for (int n = 0; n < max && sbq.size() != 0; n++) tick();
        if (sbq.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain timeout: %0d results outstanding", sbq.size());
        end
        repeat (2) tick();
    endtask

    initial begin
        vec_t tbl[8];
        bit   found;
        int   th;
        tbl[0] = '{0,          ONE,      0,         1'b0};
        tbl[1] = '{13176795,   11863283, 11863283,  1'b0};
        tbl[2] = '{-13176795,  11863283, -11863283, 1'b0};
        tbl[3] = '{26353589,   0,        ONE,       1'b0};
        tbl[4] = '{26353590,   0,        ONE,       1'b1};
        tbl[5] = '{-26353589,  0,        -ONE,      1'b0};
        tbl[6] = '{-26353590,  0,        -ONE,      1'b1};
        tbl[7] = '{8388608,    14723392, 8043426,   1'b0};

        bus.in_valid = 1'b0;
        bus.in_theta = '0;
        fork
            monitor();
            ready_drv();
        join_none

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset range_err", bus.out_range_err, 0);
        chk("reset eng_i", bus.eng_i, 0);
        chk("reset x", bus.eng_x, 0);
        chk("reset y", bus.out_sin, 0);
        chk("reset w", bus.eng_w, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Table vectors, consumer always ready
        rdy_mode = 0;
        for (int i = 0; i < 8; i++) send(tbl[i].theta, tbl[i].ec, tbl[i].es, tbl[i].ee);
        drain(100);

        // Held result with stray in_valid during RUN and DONE
        rdy_mode = 2;
        rdy_manual = 1'b0;
        tick();
        send(13176795, 11863283, 11863283, 1'b0);
        bus.in_theta = word_t'(12345);
        repeat (3) begin
            bus.in_valid = 1'b1; tick();
            bus.in_valid = 1'b0; tick();
        end
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            found = bus.out_valid;
            tick();
        end
        chk("out_valid reached", found, 1);
        for (int n = 0; n < 10; n++) begin
            bus.in_valid = n[0];
            tick();
        end
        bus.in_valid = 1'b0;
        rdy_manual = 1'b1;
        tick();
        rdy_manual = 1'b0;
        drain(20);

        // Reset mid-RUN aborts the op
        rdy_mode = 0;
        tick();
        send(8388608, 14723392, 8043426, 1'b0);
        repeat (7) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("post-abort in_ready", bus.in_ready, 1);
        chk("post-abort out_valid", bus.out_valid, 0);
        tick();
        repeat (20) tick();
        send(0, ONE, 0, 1'b0);
        drain(100);

        // Random back-to-back with random consumer stalls
        rdy_mode = 1;
        for (int i = 0; i < 100; i++) begin
            th = int'($urandom_range(2 * PI_2)) - PI_2;
            send(th, $rtoi($cos(real'(th) / 16777216.0) * 16777216.0),
                 $rtoi($sin(real'(th) / 16777216.0) * 16777216.0), 1'b0);
        end
        drain(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
